sram_data_controller: RTL and testbench
=======================================

Name: sram_data_controller

Overview:
- Sits directly downstream of the MEM stage and replaces the on-chip data memory with an external 16-bit asynchronous SRAM.
- Converts each 32-bit word load or store from the pipeline into two half-word SRAM accesses.
- Drops `ready` while an access is in progress; the pipeline combines `ready` into its freeze so that all stages hold until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 2: cycles each half-word access is held on the bus. Legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  word load request; level, held until ready=1.
- wr_en  input  1  word store request; level, held until ready=1.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data (val_rm).
- read_data  output  32  load result, registered.
- ready  output  1  0 = pipeline must freeze.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  write enable, active-low.
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0.

Behaviour:
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit modular subtraction.
  - SRAM_ADDR = {word[16:0], half}; half = 0 selects the low 16 bits, half = 1 the high 16 bits.
  - address[1:0] is ignored.
- State machine states: IDLE, LO, HI, DONE. A counter cnt runs 0..ACCESS_CYCLES-1 and clears on every state change.
- IDLE:
  - ready = !(rd_en | wr_en), combinational, so the freeze takes effect in the same cycle as the request.
  - On any request, latch op (write if wr_en else read), the word address and write_data, then go to LO.
- LO: lasts ACCESS_CYCLES cycles with half=0; on the last cycle go to HI.
- HI: lasts ACCESS_CYCLES cycles with half=1; on the last cycle go to DONE.
- DONE: ready=1 for exactly one cycle; the pipeline advances on that edge. Next state is always IDLE.
  - The request inputs are not re-sampled in DONE.
  - A new request can start in the following IDLE cycle.
- Latency: ready is low for 2*ACCESS_CYCLES+1 cycles per access (5 at default).
- Read path:
  - SRAM_DQ is tri-stated during reads.
  - read_data[15:0] captures SRAM_DQ on the edge that ends LO.
  - read_data[31:16] captures SRAM_DQ on the edge that ends HI.
  - read_data holds its value until the next read overwrites it; writes do not change it.
- Write path:
  - SRAM_DQ drives the latched low half throughout LO and the high half throughout HI.
  - SRAM_WE_N = 0 on every cycle of LO/HI except the last one, so WE_N rises before the address and data change.
  - WE_N = 1 in all other states.
- Simultaneous rd_en and wr_en: illegal; the access is treated as a write.
- Request deasserted mid-access: the access still runs to DONE.
- SRAM_ADDR in IDLE/DONE: holds the last value.
- Reset values (async, active-low), also applied on reset mid-operation:
  - state=IDLE, cnt=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1.
  - SRAM_DQ tri-stated; latched op/address/data cleared.
  - ready = !(rd_en | wr_en).
  - No partial write is completed after reset releases.

Optional Feature:
- Macro: SRAM_RANGE_CHECK_EN.
- When defined, adds output addr_err (1 bit, resets to 0).
- A request is out of range when address < BASE_ADDR, or when (address - BASE_ADDR) >= 2^19 bytes (the SRAM capacity).
- Out-of-range request in IDLE:
  - Controller goes straight to DONE with no SRAM cycle and SRAM_WE_N held at 1.
  - ready is 0 for 1 cycle, then 1 in DONE.
  - A read sets read_data = 0.
  - addr_err = 1 in that DONE cycle only.
- When undefined: no addr_err port; every address is wrapped by the 17-bit word truncation and always accessed.

Test Plan:
- Store, default parameters: wr_en=1, address=1024, write_data=0xDEADBEEF.
  - ready low 5 cycles.
  - SRAM_ADDR=0 then 1; SRAM_DQ=0xBEEF then 0xDEAD.
  - WE_N low exactly 1 cycle per half.
  - ready=1 on cycle 5.
- Load back: rd_en=1, address=1024, with the SRAM model holding 0xBEEF at address 0 and 0xDEAD at address 1.
  - read_data=0xDEADBEEF in DONE.
  - SRAM_DQ never driven by the controller.
- Back-to-back: a store to 1028 of 0x12345678, then a load from 1028 in the next IDLE.
  - SRAM_ADDR 2,3,2,3.
  - read_data=0x12345678.
  - The second access starts the cycle after DONE.
- ACCESS_CYCLES=4, load:
  - ready low 9 cycles.
  - Each half held 4 cycles.
  - read_data unchanged until the capturing edge.
- Reset mid-write: assert rst=0 during HI of a store.
  - Immediately SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
  - After release with no request: ready=1 and state IDLE.
- With SRAM_RANGE_CHECK_EN, rd_en=1 at address=512:
  - ready low 1 cycle.
  - addr_err=1 for 1 cycle, read_data=0.
  - No SRAM_WE_N activity.

Source files
------------

// File: rtl/sram_data_controller.sv
// Word-to-half-word bridge between the MEM stage and an external 16-bit asynchronous SRAM.
// Optional define SRAM_RANGE_CHECK_EN adds addr_err and skips out-of-range accesses.
module sram_data_controller #(
   parameter logic [31:0] BASE_ADDR     = 32'd1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
`ifdef SRAM_RANGE_CHECK_EN
   ,
   output logic        addr_err
`endif
);

   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_t;

   localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_op;
   logic [16:0] r_word;
   logic [31:0] r_wdata;
   logic [31:0] r_read_data;
   logic [17:0] r_sram_addr;
   logic        r_we_n;

   logic [31:0] w_offset;
   logic        w_req;
   logic        w_last;
   logic        w_next_last;
   logic        w_drive;
   logic [15:0] w_dq_out;
   logic        w_unused;

   assign w_offset    = address - BASE_ADDR;
   assign w_req       = rd_en | wr_en;
   assign w_last      = (r_cnt == LastCnt);
   assign w_next_last = ((r_cnt + 4'd1) == LastCnt);

`ifdef SRAM_RANGE_CHECK_EN
   logic w_oor;
   logic r_addr_err;
   assign w_oor    = (address < BASE_ADDR) | (|w_offset[31:19]);
   assign addr_err = r_addr_err;
   assign w_unused = ^w_offset[1:0];
`else
   assign w_unused = ^{w_offset[31:19], w_offset[1:0]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_op        <= 1'b0;
         r_word      <= 17'd0;
         r_wdata     <= 32'd0;
         r_read_data <= 32'd0;
         r_sram_addr <= 18'd0;
         r_we_n      <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
         r_addr_err  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_req) begin
                  r_op    <= wr_en;
                  r_word  <= w_offset[18:2];
                  r_wdata <= write_data;
                  r_cnt   <= 4'd0;
`ifdef SRAM_RANGE_CHECK_EN
                  if (w_oor) begin
                     r_state    <= StDone;
                     r_addr_err <= 1'b1;
                     if (!wr_en) r_read_data <= 32'd0;
                  end else
`endif
                  begin
                     r_state     <= StLo;
                     r_sram_addr <= {w_offset[18:2], 1'b0};
                     r_we_n      <= !wr_en;
                  end
               end
            end
            StLo: begin
               if (w_last) begin
                  r_state     <= StHi;
                  r_cnt       <= 4'd0;
                  r_sram_addr <= {r_word, 1'b1};
                  r_we_n      <= !r_op;
                  if (!r_op) r_read_data[15:0] <= SRAM_DQ;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  // Release WE_N one cycle early so it rises before address/data move.
                  r_we_n <= !r_op | w_next_last;
               end
            end
            StHi: begin
               if (w_last) begin
                  r_state <= StDone;
                  r_cnt   <= 4'd0;
                  r_we_n  <= 1'b1;
                  if (!r_op) r_read_data[31:16] <= SRAM_DQ;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  r_we_n <= !r_op | w_next_last;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_cnt   <= 4'd0;
`ifdef SRAM_RANGE_CHECK_EN
               r_addr_err <= 1'b0;
`endif
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Combinational in IDLE so the pipeline freezes in the same cycle as the request.
   assign ready = (r_state == StIdle) ? !w_req : (r_state == StDone);

   assign w_drive  = r_op & ((r_state == StLo) | (r_state == StHi));
   assign w_dq_out = (r_state == StHi) ? r_wdata[31:16] : r_wdata[15:0];
   assign SRAM_DQ  = w_drive ? w_dq_out : 16'hzzzz;

   assign read_data = r_read_data;
   assign SRAM_ADDR = r_sram_addr;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_data_controller.sv
// Directed bench: default-timing controller with a RAM model, plus a 4-cycle read-only instance.
module tb_sram_data_controller;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_err = 0;

   // Instance 0: default timing, backed by a small RAM model
   logic        rd0, wr0, oe0;
   logic [31:0] a0, wd0, rdata0;
   logic        rdy0, we0, ce0, oen0, ub0, lb0;
   logic [17:0] sa0;
   wire  [15:0] dq0;
   logic [15:0] mem0 [256];
`ifdef SRAM_RANGE_CHECK_EN
   logic        err0, err1;
`endif

   // Instance 1: ACCESS_CYCLES=4, reads a pattern {8'hC0, addr[7:0]}
   logic        rd1, wr1, oe1;
   logic [31:0] a1, wd1, rdata1;
   logic        rdy1, we1, ce1, oen1, ub1, lb1;
   logic [17:0] sa1;
   wire  [15:0] dq1;

   always #5 clk = ~clk;

   assign dq0 = oe0 ? mem0[sa0[7:0]] : 16'hzzzz;
   assign dq1 = oe1 ? {8'hC0, sa1[7:0]} : 16'hzzzz;

   always @(posedge we0) if (rst) mem0[sa0[7:0]] <= dq0;

   sram_data_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(a0), .write_data(wd0),
      .read_data(rdata0), .ready(rdy0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0),
      .SRAM_CE_N(ce0), .SRAM_OE_N(oen0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
`ifdef SRAM_RANGE_CHECK_EN
      , .addr_err(err0)
`endif
   );

   sram_data_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(4)) u_dut1 (
      .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(a1), .write_data(wd1),
      .read_data(rdata1), .ready(rdy1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1),
      .SRAM_CE_N(ce1), .SRAM_OE_N(oen1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
`ifdef SRAM_RANGE_CHECK_EN
      , .addr_err(err1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rd0 = 0; wr0 = 0; a0 = 0; wd0 = 0; oe0 = 0;
      rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0; oe1 = 1;
      rst = 0;
      #12;
      check("rst_ready", 32'(rdy0), 32'd1);
      check("rst_we_n", 32'(we0), 32'd1);
      check("rst_rdata", rdata0, 32'd0);
      check("rst_addr", 32'(sa0), 32'd0);
      check("rst_ready_ac4", 32'(rdy1), 32'd1);
      check("tied_pins", 32'({ce0, oen0, ub0, lb0}), 32'd0);
      @(negedge clk) rst = 1;
      cyc();

      // Store 0xDEADBEEF to byte 1024 -> SRAM 0 = BEEF, 1 = DEAD
      wr0 = 1; a0 = 32'd1024; wd0 = 32'hDEADBEEF;
      #1 check("st_ready_idle", 32'(rdy0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("st_ready", 32'(rdy0), 32'd0);
         check("st_addr", 32'(sa0), (i < 2) ? 32'd0 : 32'd1);
         check("st_we_n", 32'(we0), (i % 2 == 1) ? 32'd1 : 32'd0);
         check("st_dq", 32'(dq0), (i < 2) ? 32'h0000BEEF : 32'h0000DEAD);
      end
      cyc();
      check("st_done_ready", 32'(rdy0), 32'd1);
      check("st_done_we_n", 32'(we0), 32'd1);
      wr0 = 0;
      check("st_mem_lo", 32'(mem0[0]), 32'h0000BEEF);
      check("st_mem_hi", 32'(mem0[1]), 32'h0000DEAD);
      cyc();
      check("idle_ready", 32'(rdy0), 32'd1);

      // Load back from 1024 with the model driving the bus
      rd0 = 1; a0 = 32'd1024; oe0 = 1;
      #1 check("ld_ready_idle", 32'(rdy0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("ld_ready", 32'(rdy0), 32'd0);
         check("ld_we_n", 32'(we0), 32'd1);
         check("ld_addr", 32'(sa0), (i < 2) ? 32'd0 : 32'd1);
         check("ld_dq_undriven", 32'(dq0), (i < 2) ? 32'h0000BEEF : 32'h0000DEAD);
         if (i == 2) check("ld_rdata_lo", rdata0, 32'h0000BEEF);
      end
      cyc();
      check("ld_done_ready", 32'(rdy0), 32'd1);
      check("ld_rdata", rdata0, 32'hDEADBEEF);

      // Back-to-back: store 1028 then load 1028
      rd0 = 0; oe0 = 0; wr0 = 1; a0 = 32'd1028; wd0 = 32'h12345678;
      cyc();
      check("b2b_st_start", 32'(rdy0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("b2b_st_addr", 32'(sa0), (i < 2) ? 32'd2 : 32'd3);
         check("b2b_st_dq", 32'(dq0), (i < 2) ? 32'h00005678 : 32'h00001234);
      end
      cyc();
      check("b2b_st_done", 32'(rdy0), 32'd1);
      check("b2b_rdata_kept", rdata0, 32'hDEADBEEF);
      wr0 = 0; rd0 = 1; oe0 = 1;
      cyc();
      check("b2b_ld_start", 32'(rdy0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("b2b_ld_addr", 32'(sa0), (i < 2) ? 32'd2 : 32'd3);
      end
      cyc();
      check("b2b_ld_done", 32'(rdy0), 32'd1);
      check("b2b_ld_rdata", rdata0, 32'h12345678);
      rd0 = 0; oe0 = 0;
      cyc();

      // ACCESS_CYCLES=4 load from 1044 -> SRAM 10/11 -> 0xC00BC00A
      rd1 = 1; a1 = 32'd1044;
      #1 check("ac4_ready_idle", 32'(rdy1), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("ac4_ready", 32'(rdy1), 32'd0);
         check("ac4_addr", 32'(sa1), (i < 4) ? 32'd10 : 32'd11);
         check("ac4_rdata", rdata1, (i < 4) ? 32'd0 : 32'h0000C00A);
      end
      cyc();
      check("ac4_done_ready", 32'(rdy1), 32'd1);
      check("ac4_rdata_done", rdata1, 32'hC00BC00A);
      rd1 = 0;
      cyc();
      check("ac4_idle_ready", 32'(rdy1), 32'd1);

      // Reset during HI of a store
      wr0 = 1; a0 = 32'd1024; wd0 = 32'h55AA33CC;
      cyc(); cyc(); cyc();
      check("rw_hi_we_n", 32'(we0), 32'd0);
      check("rw_hi_dq", 32'(dq0), 32'h000055AA);
      rst = 0;
      #1;
      check("rw_we_n", 32'(we0), 32'd1);
      check("rw_rdata", rdata0, 32'd0);
      check("rw_addr", 32'(sa0), 32'd0);
      check("rw_ready_req", 32'(rdy0), 32'd0);
      wr0 = 0;
      #1 check("rw_ready_noreq", 32'(rdy0), 32'd1);
      oe0 = 1;
      #1 check("rw_dq_released", 32'(dq0), 32'h000033CC);
      oe0 = 0;
      check("rw_no_partial", 32'(mem0[1]), 32'h0000DEAD);
      @(negedge clk) rst = 1;
      cyc();
      check("rw_post_ready", 32'(rdy0), 32'd1);
      check("rw_post_we_n", 32'(we0), 32'd1);
      cyc();
      check("rw_post_ready2", 32'(rdy0), 32'd1);
      rd0 = 1; a0 = 32'd1024; oe0 = 1;
      #1 check("rw_idle_req", 32'(rdy0), 32'd0);
      for (int i = 0; i < 4; i++) cyc();
      cyc();
      check("rw_rd_ready", 32'(rdy0), 32'd1);
      check("rw_rd_data", rdata0, 32'hDEAD33CC);
      rd0 = 0; oe0 = 0;
      cyc();

`ifdef SRAM_RANGE_CHECK_EN
      rd0 = 1; a0 = 32'd512;
      #1 check("oor_ready_idle", 32'(rdy0), 32'd0);
      cyc();
      check("oor_ready_done", 32'(rdy0), 32'd1);
      check("oor_err", 32'(err0), 32'd1);
      check("oor_rdata", rdata0, 32'd0);
      check("oor_we_n", 32'(we0), 32'd1);
      rd0 = 0;
      cyc();
      check("oor_err_clear", 32'(err0), 32'd0);
      check("oor_we_n_idle", 32'(we0), 32'd1);
      check("oor_ready_idle2", 32'(rdy0), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
